uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler that shares one 8-bit UART transmitter among NUM_REQ byte sources. It accepts one byte at a time over per-requester valid/ready handshakes and launches it into the transmitter with a one-cycle start strobe. It tracks the transmitter's busy flag to frame completion, then enforces an inter-frame idle gap counted in baud-tick enables. It sits between the system's byte producers and the UART TX datapath that feeds the UART receiver side of the link.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- GAP_TICKS, 16, idle ticks of tx_clk_en inserted after each frame (0 = no gap)
- BUSY_TIMEOUT, 64, clk cycles allowed for tx_busy to rise after tx_start
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester byte-available
- req_data  in  8*NUM_REQ  requester i byte at [8i+7:8i]
- req_ready  out  NUM_REQ  one-hot acceptance pulse
- tx_data  out  8  byte presented to transmitter
- tx_start  out  1  one-cycle launch strobe
- tx_busy  in  1  transmitter frame in progress
- tx_clk_en  in  1  baud-tick enable (16x oversample tick)
- grant_id  out  clog2(NUM_REQ)  index of current/last granted requester
- sched_busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when tx_busy falls
- timeout_err  out  1  one-cycle pulse on busy timeout

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if any req_valid is high, the winner is the first set bit searching upward from (last_grant+1) mod NUM_REQ, wrapping. On the same edge, register grant_id, last_grant and tx_data <= winner's byte. Go to LAUNCH. With no valid request, stay in IDLE.
- LAUNCH: hold tx_start=1 and req_ready[grant_id]=1 for exactly this cycle, clear the timeout counter, then go to WAIT_BUSY.
- WAIT_BUSY: go to WAIT_DONE when tx_busy=1. Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1 with tx_busy still low, pulse timeout_err and go to GAP; the byte is dropped.
- WAIT_DONE: when tx_busy=0, pulse frame_done and go to GAP.
- GAP: clear the gap counter on entry. Count tx_clk_en pulses and go to IDLE on the cycle the count reaches GAP_TICKS. With GAP_TICKS=0, GAP lasts exactly one cycle.
- Requester rule: valid and data must stay stable from assertion until req_ready is seen. The transfer completes in the req_ready cycle. A requester may deassert valid in the cycle after ready.
- A requester that drops valid before it is granted is simply not selected. No error is raised.
- tx_data holds the last launched byte until the next grant.
- last_grant resets to NUM_REQ-1, so requester 0 has first priority after reset.
- Only one bit of req_ready is ever high, and it is high only in LAUNCH.

## Timing
- Reset values (asynchronous, immediate): state IDLE, tx_start 0, tx_data 0x00, req_ready 0, grant_id 0, last_grant NUM_REQ-1, sched_busy 0, frame_done 0, timeout_err 0, all counters 0.
- Latency from req_valid rising in IDLE (sampled at edge N):
  - tx_start and req_ready are high in the cycle after edge N.
  - Minimum 1 cycle request-to-launch.
- Back-to-back throughput: LAUNCH (1) + busy wait + frame + GAP + 1 IDLE cycle. Requests are never accepted in IDLE's arbitration cycle without first leaving GAP.
- A tx_busy rise in the LAUNCH cycle is ignored. Detection begins in WAIT_BUSY.
- Simultaneous frame_done and new requests: the requests wait until GAP completes, and arbitration uses the post-frame last_grant.
- Reset asserted mid-frame: outputs clear immediately and tx_start never re-fires for the lost byte. After reset, the requester must re-present the byte (its valid is still high, so it is regranted in normal order).
- Counter widths:
  - timeout counter is clog2(BUSY_TIMEOUT+1) bits.
  - gap counter is clog2(GAP_TICKS+1) bits.
  - Neither counter wraps; each saturates at its terminal count.

## Test plan
- Single requester: req_valid=0001, data0=0xA5, transmitter model asserts busy 2 cycles after start for 160 cycles -> one tx_start with tx_data=0xA5, req_ready=0001 in the same cycle, frame_done once, grant_id=0.
- All four requesters valid continuously with bytes 0x11/0x22/0x33/0x44 -> launch order 0,1,2,3,0… The tx_data sequence repeats 0x11,0x22,0x33,0x44, and there are exactly GAP_TICKS tx_clk_en ticks between each frame_done and the next tx_start.
- Wrap-around fairness: last_grant=3, valid=1010 -> requester 1 granted; next grant is 3 while 1 stays valid.
- Busy never rises: one request, tx_busy tied 0 -> timeout_err pulses BUSY_TIMEOUT cycles after WAIT_BUSY entry, no frame_done, return to IDLE after the gap.
- GAP_TICKS=0 with continuous requests -> next tx_start exactly 2 cycles after frame_done.
- Reset pulse during WAIT_DONE -> all outputs 0 within the same cycle. After release with valid=0100, requester 2 is granted and tx_start fires 1 cycle later.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester handshakes plus the transmitter data/start/busy link.
// master: the scheduler (drives req_ready, tx_data, tx_start; samples the rest).
// slave: the environment (requesters and the UART transmitter).
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;

  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_data, tx_start
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_data, tx_start
  );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Latency: tx_start/req_ready one cycle after a valid request is sampled in IDLE.
// Backpressure: one byte per frame; requesters hold valid/data until their req_ready pulse,
// the next grant waits for frame end (or busy timeout) plus GAP_TICKS baud ticks.
// Ports: clk/rst_n; bus (requesters + transmitter link); tx_clk_en baud tick;
// grant_id, sched_busy, frame_done, timeout_err status outputs.
module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_TICKS    = 16,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  uart_tx_sched_if.master            bus,
  input  logic                       tx_clk_en,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       sched_busy,
  output logic                       frame_done,
  output logic                       timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  // A zero gap still needs a 1-bit counter to keep the datapath legal.
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(GAP_TICKS);
  localparam logic [GW-1:0] GAP_LAST = (GAP_TICKS > 0) ? GW'(GAP_TICKS - 1) : '0;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] last_grant, last_nxt, grant_nxt;
  logic [7:0]    tx_data_q, data_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic          fd_nxt, te_nxt;

  logic          win_vld;
  logic [IW-1:0] win_id;
  logic [7:0]    win_dat;
  int            idx;

  // Search upward from last_grant+1; scanning from the far end and overwriting
  // leaves the nearest set bit as the winner.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(last_grant) + 1 + k) % NUM_REQ;
      if (bus.req_valid[IW'(idx)]) begin
        win_vld = 1'b1;
        win_id  = IW'(idx);
      end
    end
  end

  always_comb begin
    win_dat = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_id == IW'(k)) win_dat = bus.req_data[8*k +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    last_nxt  = last_grant;
    data_nxt  = tx_data_q;
    to_nxt    = to_cnt;
    gap_nxt   = gap_cnt;
    fd_nxt    = 1'b0;
    te_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = LAUNCH;
          grant_nxt = win_id;
          last_nxt  = win_id;
          data_nxt  = win_dat;
        end
      end
      LAUNCH: begin
        // A busy rise during the strobe cycle is deliberately not looked at.
        to_nxt    = '0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          te_nxt    = 1'b1;
          gap_nxt   = '0;
          state_nxt = GAP;
        end else begin
          to_nxt = to_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          fd_nxt    = 1'b1;
          gap_nxt   = '0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        // Leave on the tick that completes the gap; a zero gap exits at once.
        if (gap_cnt == GAP_END) begin
          state_nxt = IDLE;
        end else if (tx_clk_en) begin
          gap_nxt = gap_cnt + 1'b1;
          if (gap_cnt == GAP_LAST) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_id    <= '0;
      last_grant  <= IW'(NUM_REQ - 1);
      tx_data_q   <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant_id    <= grant_nxt;
      last_grant  <= last_nxt;
      tx_data_q   <= data_nxt;
      to_cnt      <= to_nxt;
      gap_cnt     <= gap_nxt;
      frame_done  <= fd_nxt;
      timeout_err <= te_nxt;
    end
  end

  // Strobes decode straight from the state register so reset clears them at once.
  assign bus.tx_start  = (state == LAUNCH);
  assign bus.req_ready = (state == LAUNCH) ? (NUM_REQ'(1) << grant_id) : '0;
  assign bus.tx_data   = tx_data_q;
  assign sched_busy    = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed bench for uart_tx_sched with a busy-flag transmitter model.
// dut1 uses GAP_TICKS=16, dut2 uses GAP_TICKS=0; both share clk, rst_n and the baud tick.
// Outputs are sampled 1ns after the falling edge; inputs are driven at the same point.
module tb_uart_tx_sched;
  localparam int FRAME = 160;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic tx_clk_en = 1'b0;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.NUM_REQ(4)) bus1 ();
  uart_tx_sched_if #(.NUM_REQ(4)) bus2 ();

  logic [1:0] gid1, gid2;
  logic       sb1, fd1, te1, sb2, fd2, te2;

  uart_tx_sched #(.NUM_REQ(4), .GAP_TICKS(16), .BUSY_TIMEOUT(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .tx_clk_en(tx_clk_en),
    .grant_id(gid1), .sched_busy(sb1), .frame_done(fd1), .timeout_err(te1)
  );

  uart_tx_sched #(.NUM_REQ(4), .GAP_TICKS(0), .BUSY_TIMEOUT(64)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .tx_clk_en(tx_clk_en),
    .grant_id(gid2), .sched_busy(sb2), .frame_done(fd2), .timeout_err(te2)
  );

  // Baud tick: one pulse every 4 clocks.
  int tick_ph = 0;
  always @(negedge clk) begin
    tick_ph   = (tick_ph + 1) % 4;
    tx_clk_en = (tick_ph == 0);
  end

  // Transmitter model for dut1: busy rises 2 cycles after tx_start, lasts FRAME cycles.
  bit m_en    = 1'b1;
  int m_dly   = 0;
  int m_frame = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      bus1.tx_busy = 1'b0;
      m_dly        = 0;
      m_frame      = 0;
    end else begin
      if (m_dly > 0) begin
        m_dly--;
        if (m_dly == 0) begin
          bus1.tx_busy = 1'b1;
          m_frame      = FRAME;
        end
      end else if (m_frame > 0) begin
        m_frame--;
        if (m_frame == 0) bus1.tx_busy = 1'b0;
      end
      if (bus1.tx_start && m_en) m_dly = 2;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Wait for dut1 tx_start; counts baud ticks from the first frame_done seen up to the launch.
  task automatic wait_start1(input int max, output bit ok, output int ticks);
    bit seen_fd;
    ok      = 1'b0;
    ticks   = 0;
    seen_fd = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (bus1.tx_start) begin
        ok = 1'b1;
        break;
      end
      if (fd1) seen_fd = 1'b1;
      if (seen_fd && tx_clk_en) ticks++;
    end
  endtask

  // Wait for dut1 to return to IDLE, counting events on the way.
  task automatic wait_idle1(input int max, output bit ok, output int nfd, output int nte,
                            output int nst);
    ok  = 1'b0;
    nfd = 0;
    nte = 0;
    nst = 0;
    for (int i = 0; i < max; i++) begin
      step();
      if (!sb1) begin
        ok = 1'b1;
        break;
      end
      if (fd1) nfd++;
      if (te1) nte++;
      if (bus1.tx_start) nst++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int ticks, n, nfd, nte, nst;
    bus1.req_valid = '0;
    bus1.req_data  = '0;
    bus2.req_valid = '0;
    bus2.req_data  = '0;
    bus2.tx_busy   = 1'b0;
    rst_n          = 1'b0;

    // Reset state
    step();
    check("rst_tx_start", bus1.tx_start, 0);
    check("rst_tx_data", bus1.tx_data, 8'h00);
    check("rst_req_ready", bus1.req_ready, 0);
    check("rst_grant_id", gid1, 0);
    check("rst_sched_busy", sb1, 0);
    check("rst_frame_done", fd1, 0);
    check("rst_timeout_err", te1, 0);
    check("rst2_status", {sb2, fd2, te2, gid2}, 0);
    rst_n = 1'b1;

    // Single requester, one-cycle request-to-launch
    bus1.req_data  = 32'h0000_00A5;
    bus1.req_valid = 4'b0001;
    step();
    check("t1_tx_start", bus1.tx_start, 1);
    check("t1_req_ready", bus1.req_ready, 4'b0001);
    check("t1_tx_data", bus1.tx_data, 8'hA5);
    check("t1_grant_id", gid1, 0);
    check("t1_sched_busy", sb1, 1);
    step();
    bus1.req_valid = '0;
    check("t1_start_one_cycle", bus1.tx_start, 0);
    wait_idle1(600, ok, nfd, nte, nst);
    check("t1_idle", ok, 1);
    check("t1_frame_done_cnt", nfd, 1);
    check("t1_timeout_cnt", nte, 0);
    check("t1_restart_cnt", nst, 0);
    check("t1_tx_data_held", bus1.tx_data, 8'hA5);

    // Fresh reset so requester 0 leads; all four continuously valid
    rst_n = 1'b0;
    step();
    rst_n          = 1'b1;
    bus1.req_data  = 32'h4433_2211;
    bus1.req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      wait_start1(600, ok, ticks);
      check("rr_launch_seen", ok, 1);
      check("rr_grant_id", gid1, i % 4);
      check("rr_tx_data", bus1.tx_data, 8'h11 * ((i % 4) + 1));
      check("rr_req_ready", bus1.req_ready, 4'b0001 << (i % 4));
      if (i > 0) check("rr_gap_ticks", ticks, 16);
    end
    step();
    bus1.req_valid = '0;
    wait_idle1(600, ok, nfd, nte, nst);
    check("rr_idle", ok, 1);

    // Wrap-around fairness: make 3 the last grant, then 1 and 3 compete
    bus1.req_valid = 4'b1000;
    wait_start1(10, ok, ticks);
    check("wrap_setup_grant", gid1, 3);
    step();
    bus1.req_valid = '0;
    wait_idle1(600, ok, nfd, nte, nst);
    check("wrap_setup_idle", ok, 1);
    bus1.req_valid = 4'b1010;
    wait_start1(10, ok, ticks);
    check("wrap_first_grant", gid1, 1);
    check("wrap_first_ready", bus1.req_ready, 4'b0010);
    check("wrap_first_data", bus1.tx_data, 8'h22);
    wait_start1(600, ok, ticks);
    check("wrap_second_grant", gid1, 3);
    check("wrap_second_data", bus1.tx_data, 8'h44);
    step();
    bus1.req_valid = '0;
    wait_idle1(600, ok, nfd, nte, nst);
    check("wrap_idle", ok, 1);

    // Busy never rises: timeout BUSY_TIMEOUT cycles after WAIT_BUSY entry
    m_en           = 1'b0;
    bus1.req_valid = 4'b0100;
    wait_start1(10, ok, ticks);
    check("to_grant", gid1, 2);
    n   = 0;
    nfd = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      n++;
      if (n == 1) bus1.req_valid = '0;
      if (fd1) nfd++;
      if (te1) break;
    end
    check("to_latency", n, 65);
    check("to_no_frame_done", nfd, 0);
    step();
    check("to_pulse_width", te1, 0);
    check("to_in_gap", sb1, 1);
    wait_idle1(600, ok, nfd, nte, nst);
    check("to_idle", ok, 1);
    check("to_gap_frame_done", nfd, 0);
    m_en = 1'b1;

    // dut2, zero gap: next launch exactly 2 cycles after frame_done
    bus2.req_data  = 32'h0000_6655;
    bus2.req_valid = 4'b0011;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus2.tx_start) begin
        ok = 1'b1;
        break;
      end
    end
    check("g0_first_launch", ok, 1);
    check("g0_first_grant", gid2, 0);
    check("g0_first_data", bus2.tx_data, 8'h55);
    step();
    bus2.tx_busy = 1'b1;
    repeat (4) step();
    bus2.tx_busy = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (fd2) begin
        ok = 1'b1;
        break;
      end
    end
    check("g0_frame_done", ok, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (bus2.tx_start) break;
    end
    check("g0_restart_delay", n, 2);
    check("g0_second_grant", gid2, 1);
    check("g0_second_data", bus2.tx_data, 8'h66);
    step();
    bus2.req_valid = '0;

    // Reset in WAIT_DONE, then requester 2 regranted one cycle after release
    bus1.req_valid = 4'b0001;
    wait_start1(10, ok, ticks);
    check("rs_grant", gid1, 0);
    step();
    bus1.req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus1.tx_busy) break;
    end
    step();
    step();
    check("rs_mid_frame", sb1, 1);
    bus1.req_valid = 4'b0100;
    rst_n          = 1'b0;
    #1;
    check("rs_tx_start", bus1.tx_start, 0);
    check("rs_tx_data", bus1.tx_data, 8'h00);
    check("rs_req_ready", bus1.req_ready, 0);
    check("rs_grant_id", gid1, 0);
    check("rs_sched_busy", sb1, 0);
    check("rs_flags", {fd1, te1}, 0);
    step();
    rst_n = 1'b1;
    check("rs_no_refire", bus1.tx_start, 0);
    step();
    check("rs_relaunch", bus1.tx_start, 1);
    check("rs_relaunch_grant", gid1, 2);
    check("rs_relaunch_ready", bus1.req_ready, 4'b0100);
    check("rs_relaunch_data", bus1.tx_data, 8'h33);
    step();
    bus1.req_valid = '0;
    wait_idle1(600, ok, nfd, nte, nst);
    check("rs_final_idle", ok, 1);
    check("rs_final_frame_done", nfd, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
